// File: rtl/conv_stream_tx_if.sv
// AXI4-Stream link between conv_stream_tx and its sink.
// CONV_STREAM_TX_TUSER_EN adds the start-of-frame tuser bit.
interface conv_stream_tx_if #(
  parameter int unsigned NB_DATA = 32
);
  logic [NB_DATA-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
`ifdef CONV_STREAM_TX_TUSER_EN
  logic               tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/conv_stream_tx.sv
// Convolver result collector: FWFT FIFO with registered output stage feeding an AXI4-Stream master.
// Optional start-of-frame tuser output enabled by CONV_STREAM_TX_TUSER_EN.
module conv_stream_tx #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned FRAME_WORDS = 2500,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned AF_MARGIN   = 4,
  parameter int unsigned NB_CNT      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_overflow,
  output logic               o_frame_done,
  conv_stream_tx_if.master   m_axis
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned AF_THR = FIFO_DEPTH - AF_MARGIN;

  logic [NB_DATA-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      occ;
  logic [NB_CNT-1:0]  cnt;
  logic [NB_DATA-1:0] tdata_q;
  logic               tvalid_q, tlast_q, tuser_q;
  logic               ready_q, ovf_q, fd_q;

  logic               pop_c, push_c, full_c, mem_empty_c, load_c, last_c;
  logic               tvalid_n, tlast_n, tuser_n, ready_n;
  logic [CW-1:0]      occ_n;
  logic [NB_CNT-1:0]  cnt_n;

  // Handshake, occupancy and next-beat bookkeeping
  always_comb begin
    pop_c       = tvalid_q & m_axis.tready;
    full_c      = (occ == CW'(FIFO_DEPTH));
    push_c      = i_valid & (~full_c | pop_c);
    mem_empty_c = (wr_ptr == rd_ptr);
    load_c      = ~mem_empty_c & (~tvalid_q | pop_c);
    last_c      = (cnt == NB_CNT'(FRAME_WORDS - 1));
    tvalid_n    = load_c | (tvalid_q & ~pop_c);
    cnt_n       = cnt;
    if (pop_c) cnt_n = last_c ? '0 : NB_CNT'(cnt + NB_CNT'(1));
    occ_n       = occ;
    if (push_c && !pop_c) occ_n = CW'(occ + CW'(1));
    if (!push_c && pop_c) occ_n = CW'(occ - CW'(1));
    tlast_n     = tvalid_n & (cnt_n == NB_CNT'(FRAME_WORDS - 1));
    tuser_n     = tvalid_n & (cnt_n == '0);
    ready_n     = (occ_n <= CW'(AF_THR));
  end

  // Storage array carries no reset; only pointers define its contents
  always_ff @(posedge i_clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      cnt      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (load_c) begin
        rd_ptr  <= PW'(rd_ptr + PW'(1));
        tdata_q <= mem[rd_ptr[AW-1:0]];
      end
      occ      <= occ_n;
      cnt      <= cnt_n;
      tvalid_q <= tvalid_n;
      tlast_q  <= tlast_n;
      tuser_q  <= tuser_n;
      ready_q  <= ready_n;
      fd_q     <= pop_c & last_c;
      if (i_valid && !push_c) ovf_q <= 1'b1;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign o_ready       = ready_q;
  assign o_overflow    = ovf_q;
  assign o_frame_done  = fd_q;

`ifdef CONV_STREAM_TX_TUSER_EN
  assign m_axis.tuser = tuser_q;
`else
  logic unused_tuser;
  assign unused_tuser = tuser_q;
`endif

endmodule
